// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port between fetch and data requesters, with timeout abort
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic                  if_err,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_done,
  output logic                  d_err,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [7:0] TO = 8'(TIMEOUT);
  state_t                state_q, state_d;
  logic                  last_q, cur_q, err_q, mem_we_q;
  logic                  pick, grant, finish;
  logic [7:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q, if_rdata_q, d_rdata_q, rdata_d;
  // arbitration and completion decode: on contention serve the port that did not win last time
  always_comb begin
    pick    = (if_req & d_req) ? ~last_q : d_req;
    grant   = (state_q != BUSY) & (if_req | d_req);
    finish  = (state_q == BUSY) & (mem_ack | (cnt_q + 8'd1 == TO));
    cnt_d   = (state_q == BUSY && !finish) ? cnt_q + 8'd1 : 8'd0;
    rdata_d = (mem_ack & ~mem_we_q) ? mem_rdata : '0;
  end
  // state register
  always_ff @(posedge clk)
    state_q <= !rst_n ? IDLE : state_d;
  // next state: BUSY until ack or budget spent, otherwise re-arbitrate
  always_comb
    state_d = finish ? DONE : (state_q == BUSY || grant) ? BUSY : IDLE;
  // outputs decoded from state; done pulses belong to the port that owns the transaction
  always_comb begin
    mem_req   = state_q == BUSY;
    busy      = state_q != IDLE;
    if_done   = (state_q == DONE) & ~cur_q;
    d_done    = (state_q == DONE) & cur_q;
    if_err    = if_done & err_q;
    d_err     = d_done & err_q;
    if_rdata  = if_rdata_q;
    d_rdata   = d_rdata_q;
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
  end
  // transaction latch, round-robin history, timeout counter and per-port results
  always_ff @(posedge clk)
    if (!rst_n) begin
      last_q      <= 1'b1;
      cur_q       <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (grant) begin
        cur_q       <= pick;
        last_q      <= pick;
        mem_we_q    <= pick & d_we;
        mem_addr_q  <= pick ? d_addr : if_addr;
        mem_wdata_q <= pick ? d_wdata : '0;
      end
      if (finish) begin
        err_q <= ~mem_ack;
        if (cur_q) d_rdata_q <= rdata_d;
        else if_rdata_q <= rdata_d;
      end
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single memory port of the multicycle CPU between the instruction-fetch path and the load/store data path. Each requester issues a request and waits for a one-cycle done pulse carrying read data or an error flag. The arbiter grants the port round-robin, holds the memory-side request stable until acknowledged, and aborts transactions that exceed a cycle budget. It sits between the control-sequenced datapath (fetch / LOAD / STORE states) and the memory model.

## Interface
- ADDR_WIDTH, 16, address width
- DATA_WIDTH, 16, data width
- TIMEOUT, 15, max BUSY cycles without mem_ack before abort (1..255)
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- if_req  in  1  fetch read request
- if_addr  in  ADDR_WIDTH  fetch address
- if_done  out  1  one-cycle completion pulse, fetch
- if_err  out  1  fetch timed out; valid with if_done
- if_rdata  out  DATA_WIDTH  fetch read data
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_done  out  1  one-cycle completion pulse, data
- d_err  out  1  data timed out; valid with d_done
- d_rdata  out  DATA_WIDTH  load data (0 after a store)
- mem_req  out  1  memory request, held until ack or abort
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_ack  in  1  memory completion; mem_rdata valid same cycle
- mem_rdata  in  DATA_WIDTH  memory read data
- busy  out  1  high in BUSY and DONE

## Operation
- States: IDLE, BUSY, DONE. Reset → IDLE.
- Reset values: all outputs 0; last_grant = DATA; timeout counter 0.
- Arbitration (in IDLE and DONE): only if_req → fetch; only d_req → data; both → the port not in last_grant. Winner's address/we/wdata latched into mem_* registers; last_grant updated; → BUSY. No request → IDLE.
- Fetch transactions always have mem_we = 0, mem_wdata = 0.
- BUSY: mem_req = 1; mem_we/mem_addr/mem_wdata constant. Counter increments each BUSY cycle.
  - mem_ack = 1 → capture mem_rdata (loads/fetch), → DONE, err = 0.
  - counter reaches TIMEOUT with mem_ack = 0 → → DONE, err = 1, rdata captured as 0.
  - mem_ack in the same cycle the counter reaches TIMEOUT: ack wins, err = 0.
- DONE: granted port's done = 1 for exactly this cycle; err valid; mem_req = 0; counter cleared. Arbitrate as in IDLE.
- *_rdata registered; updated only on that port's done, held otherwise. Store completion sets d_rdata = 0.
- Requesters hold req and inputs until done. Request dropped after grant: transaction still completes and pulses done. Request still asserted in the done cycle counts as a new request.
- mem_ack outside BUSY is ignored.
- rst_n low mid-transaction: next edge returns to IDLE, mem_req = 0, no done pulse issued.

## Timing
- Request sampled at edge N (IDLE) → mem_req high from N+1.
- mem_ack sampled at edge M → done/rdata high in cycle M+1, mem_req low in M+1.
- Minimum latency: request to done = 2 cycles (ack in first BUSY cycle).
- Back-to-back: next mem_req one cycle after done (DONE→BUSY); port never idles between queued requests.
- Timeout: mem_req high for exactly TIMEOUT cycles, then done with err.
- Both requests asserted continuously: grants strictly alternate fetch, data, fetch, … (fetch first after reset).

## Test plan
- Single fetch: if_req, if_addr=0x0010, memory acks after 1 cycle with 0xBEEF → mem_req 1 cycle, if_done pulse 2 cycles after request, if_rdata=0xBEEF, if_err=0.
- Store then load: d_we=1 addr=0x0020 wdata=0x1234, then d_we=0 same addr; memory acks after 3 cycles → mem_we=1 with wdata 0x1234 for store; load returns 0x1234; d_rdata=0 after store; each d_done a single pulse.
- Contention: if_req and d_req held high from reset, 6 transactions, ack after 1 cycle → grant order F,D,F,D,F,D; mem_req low exactly 1 cycle between transactions.
- Timeout: TIMEOUT=15, no mem_ack → mem_req high 15 cycles, d_done with d_err=1, d_rdata=0; then normal fetch succeeds.
- Ack on final cycle: mem_ack exactly on the 15th BUSY cycle → err=0, data captured.
- Reset mid-BUSY: rst_n low 1 cycle during BUSY → mem_req 0 next cycle, no done pulse, all outputs 0, next simultaneous request grants fetch.
